// File: rtl/gray_bin_pipe.sv
// gray_bin_pipe: pipelined Gray<->binary converter with valid/ready handshakes on both sides.
//
// Every accepted word carries its own direction bit. Gray->binary words are resolved
// MSB-first across STAGES register stages, at most ceil(WIDTH/STAGES) bits per stage.
// Binary->Gray words are converted in stage 0 and then delayed, so both directions have
// the same fixed latency of STAGES cycles and results never reorder.
// Gray->binary inputs are also checked against the previous Gray->binary input: if they
// differ in more than one bit, the result is flagged and a saturating counter records it.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input word present
//   in_ready   block accepts a word this cycle (combinational from out_ready/out_valid)
//   in_mode    0 = Gray->binary, 1 = binary->Gray
//   in_data    word to convert
//   out_valid  result present
//   out_ready  downstream accepts the result
//   out_data   converted word
//   out_mode   in_mode of this result
//   step_err   this Gray->binary result broke the one-bit-step rule
//   err_count  saturating count of step errors transferred out
//   clr_err    synchronous clear of err_count, wins over a simultaneous increment

module gray_bin_pipe #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2,
  parameter int unsigned ERRW   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode,
  output logic             step_err,
  output logic [ERRW-1:0]  err_count,
  input  logic             clr_err
);

  // Gray bits resolved per stage.
  localparam int unsigned Chunk = (WIDTH + STAGES - 1) / STAGES;

  localparam logic [ERRW-1:0] CntMax = '1;

  // Resolve the slice of the XOR prefix chain owned by stage s. Bits above the slice are
  // already binary, bits below it are still Gray, so the chain can be continued in place.
  function automatic logic [WIDTH-1:0] g2b_part(input logic [WIDTH-1:0] w, input int s);
    logic [WIDTH-1:0] r;
    int               hi;
    int               lo;
    r  = w;
    hi = int'(WIDTH) - 1 - s * int'(Chunk);
    lo = int'(WIDTH) - (s + 1) * int'(Chunk);
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      if (i <= hi && i >= lo) begin
        r[i] = r[i+1] ^ r[i];
      end
    end
    return r;
  endfunction

  // Stage registers; the last stage drives the outputs directly.
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] mode_q;
  logic [STAGES-1:0] err_q;
  logic [WIDTH-1:0]  data_q [STAGES];

  // Next-state candidates for each stage when the pipeline advances.
  logic [STAGES-1:0] src_valid;
  logic [STAGES-1:0] src_mode;
  logic [STAGES-1:0] src_err;
  logic [WIDTH-1:0]  src_data [STAGES];

  // Gray history for the step check.
  logic [WIDTH-1:0] hist_q;
  logic             hist_vld_q;

  logic [ERRW-1:0] err_cnt_q;

  logic             adv;
  logic             accept;
  logic [WIDTH-1:0] diff;
  logic             multi_bit;
  logic             new_err;
  logic [WIDTH-1:0] b2g;

  // The whole pipeline moves in lockstep: it advances whenever the output slot is free
  // or being drained this cycle.
  assign adv      = out_ready | ~valid_q[STAGES-1];
  assign in_ready = adv;
  assign accept   = in_valid & in_ready;

  // More than one differing bit <=> clearing the lowest set bit leaves something set.
  assign diff      = in_data ^ hist_q;
  assign multi_bit = |(diff & (diff - WIDTH'(1)));
  assign new_err   = ~in_mode & hist_vld_q & multi_bit;

  assign b2g = in_data ^ (in_data >> 1);

  always_comb begin
    for (int s = 0; s < int'(STAGES); s++) begin
      src_valid[s] = 1'b0;
      src_mode[s]  = 1'b0;
      src_err[s]   = 1'b0;
      src_data[s]  = '0;
    end

    src_valid[0] = accept;
    src_mode[0]  = in_mode;
    src_err[0]   = new_err;
    src_data[0]  = in_mode ? b2g : g2b_part(in_data, 0);

    for (int s = 1; s < int'(STAGES); s++) begin
      src_valid[s] = valid_q[s-1];
      src_mode[s]  = mode_q[s-1];
      src_err[s]   = err_q[s-1];
      // Binary->Gray words are already final; they only ride along.
      src_data[s]  = mode_q[s-1] ? data_q[s-1] : g2b_part(data_q[s-1], s);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      mode_q  <= '0;
      err_q   <= '0;
      for (int s = 0; s < int'(STAGES); s++) begin
        data_q[s] <= '0;
      end
    end else if (adv) begin
      valid_q <= src_valid;
      // Bubbles never carry an error flag, so step_err cannot be seen without out_valid.
      err_q   <= src_valid & src_err;
      for (int s = 0; s < int'(STAGES); s++) begin
        if (src_valid[s]) begin
          data_q[s] <= src_data[s];
          mode_q[s] <= src_mode[s];
        end
      end
    end
  end

  // Only Gray->binary transfers touch the history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q     <= '0;
      hist_vld_q <= 1'b0;
    end else if (accept && !in_mode) begin
      hist_q     <= in_data;
      hist_vld_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (clr_err) begin
      err_cnt_q <= '0;
    end else if (valid_q[STAGES-1] && out_ready && err_q[STAGES-1] && (err_cnt_q != CntMax)) begin
      err_cnt_q <= err_cnt_q + ERRW'(1);
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign out_mode  = mode_q[STAGES-1];
  assign step_err  = err_q[STAGES-1];
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_gray_bin_pipe.sv
module tb_gray_bin_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       in_mode;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_mode;
  logic       step_err;
  logic [1:0] err_count;
  logic       clr_err;

  int total = 0;
  int bad   = 0;

  logic [3:0] gray_tab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                                4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                4'b1010, 4'b1011, 4'b1001, 4'b1000};

  gray_bin_pipe #(
    .WIDTH (4),
    .STAGES(2),
    .ERRW  (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mode  (in_mode),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_mode (out_mode),
    .step_err (step_err),
    .err_count(err_count),
    .clr_err  (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    clr_err   = 1'b0;
    out_ready = 1'b1;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_data   = 4'b0000;
    out_ready = 1'b1;
    clr_err   = 1'b0;
    tick;
    tick;
    chk("rst_out_valid", 32'(out_valid), 32'b0);
    chk("rst_out_data", 32'(out_data), 32'b0);
    chk("rst_out_mode", 32'(out_mode), 32'b0);
    chk("rst_step_err", 32'(step_err), 32'b0);
    chk("rst_err_count", 32'(err_count), 32'b0);
    chk("rst_in_ready", 32'(in_ready), 32'b1);
    rst_n = 1'b1;
    tick;

    // Single Gray->binary word, latency 2.
    in_valid = 1'b1;
    in_mode  = 1'b0;
    in_data  = 4'b0110;
    tick;
    in_valid = 1'b0;
    chk("lat_early_valid", 32'(out_valid), 32'b0);
    tick;
    chk("lat_valid", 32'(out_valid), 32'b1);
    chk("lat_data", 32'(out_data), 32'b0100);
    chk("lat_step_err", 32'(step_err), 32'b0);
    chk("lat_mode", 32'(out_mode), 32'b0);
    tick;
    chk("lat_after_valid", 32'(out_valid), 32'b0);

    // Back-to-back Gray count sweep.
    do_reset;
    for (int t = 0; t <= 16; t++) begin
      if (t < 16) begin
        in_valid = 1'b1;
        in_mode  = 1'b0;
        in_data  = gray_tab[t];
      end else begin
        in_valid = 1'b0;
      end
      tick;
      if (t >= 1) begin
        chk("sweep_valid", 32'(out_valid), 32'b1);
        chk("sweep_data", 32'(out_data), 32'(t - 1));
        chk("sweep_step_err", 32'(step_err), 32'b0);
      end
    end
    tick;
    chk("sweep_drain_valid", 32'(out_valid), 32'b0);
    chk("sweep_err_count", 32'(err_count), 32'b0);

    // Mixed directions; mode-1 words must not disturb the history.
    do_reset;
    in_valid = 1'b1;
    in_mode  = 1'b0;
    in_data  = 4'b0011;
    tick;
    in_mode = 1'b1;
    in_data = 4'b1011;
    tick;
    chk("mix0_data", 32'(out_data), 32'b0010);
    chk("mix0_mode", 32'(out_mode), 32'b0);
    chk("mix0_err", 32'(step_err), 32'b0);
    in_data = 4'b1100;
    tick;
    chk("mix1_data", 32'(out_data), 32'b1110);
    chk("mix1_mode", 32'(out_mode), 32'b1);
    chk("mix1_err", 32'(step_err), 32'b0);
    in_mode = 1'b0;
    in_data = 4'b0010;
    tick;
    chk("mix2_data", 32'(out_data), 32'b1010);
    chk("mix2_mode", 32'(out_mode), 32'b1);
    chk("mix2_err", 32'(step_err), 32'b0);
    in_valid = 1'b0;
    tick;
    chk("mix3_data", 32'(out_data), 32'b0011);
    chk("mix3_mode", 32'(out_mode), 32'b0);
    chk("mix3_err", 32'(step_err), 32'b0);
    tick;
    chk("mix_drain_valid", 32'(out_valid), 32'b0);

    // Step errors: 0000 -> 0011 breaks the rule, repeating 0011 does not.
    do_reset;
    in_valid = 1'b1;
    in_mode  = 1'b0;
    in_data  = 4'b0000;
    tick;
    in_data = 4'b0011;
    tick;
    chk("step0_data", 32'(out_data), 32'b0000);
    chk("step0_err", 32'(step_err), 32'b0);
    tick;
    chk("step1_data", 32'(out_data), 32'b0010);
    chk("step1_err", 32'(step_err), 32'b1);
    chk("step1_count", 32'(err_count), 32'b0);
    in_valid = 1'b0;
    tick;
    chk("step2_data", 32'(out_data), 32'b0010);
    chk("step2_err", 32'(step_err), 32'b0);
    chk("step2_count", 32'(err_count), 32'b1);
    tick;
    chk("step_count_hold", 32'(err_count), 32'b1);
    chk("step_drain_valid", 32'(out_valid), 32'b0);

    // Backpressure with a full pipeline.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 1'b1;
    in_data   = 4'b0001;
    #1;
    chk("bp_ready_empty", 32'(in_ready), 32'b1);
    tick;
    in_data = 4'b0010;
    #1;
    chk("bp_ready_half", 32'(in_ready), 32'b1);
    tick;
    in_data = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      chk("bp_stall_ready", 32'(in_ready), 32'b0);
      chk("bp_stall_valid", 32'(out_valid), 32'b1);
      chk("bp_stall_data", 32'(out_data), 32'b0001);
      tick;
    end
    chk("bp_stall_data_end", 32'(out_data), 32'b0001);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'b1);
    tick;
    in_valid = 1'b0;
    chk("bp_w1_valid", 32'(out_valid), 32'b1);
    chk("bp_w1_data", 32'(out_data), 32'b0011);
    tick;
    chk("bp_w2_valid", 32'(out_valid), 32'b1);
    chk("bp_w2_data", 32'(out_data), 32'b0110);
    tick;
    chk("bp_drain_valid", 32'(out_valid), 32'b0);

    // Saturation: five errors into a 2-bit counter.
    do_reset;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      in_mode  = 1'b0;
      in_data  = (k % 2 == 1) ? 4'b0011 : 4'b0000;
      tick;
    end
    in_valid = 1'b0;
    tick;
    tick;
    tick;
    chk("sat_count", 32'(err_count), 32'b11);
    clr_err = 1'b1;
    tick;
    clr_err = 1'b0;
    chk("clr_plain", 32'(err_count), 32'b0);

    // Clear coinciding with an error transfer (history holds 0011).
    in_valid = 1'b1;
    in_data  = 4'b0000;
    tick;
    in_valid = 1'b0;
    tick;
    chk("clr_hit_err", 32'(step_err), 32'b1);
    clr_err = 1'b1;
    tick;
    clr_err = 1'b0;
    chk("clr_hit_count", 32'(err_count), 32'b0);
    tick;
    chk("clr_hit_count_hold", 32'(err_count), 32'b0);

    // Reset in the middle of a stream (history holds 0000).
    in_valid = 1'b1;
    in_mode  = 1'b0;
    in_data  = 4'b0011;
    tick;
    in_mode = 1'b1;
    in_data = 4'b0001;
    tick;
    in_data = 4'b0010;
    tick;
    chk("mid_count", 32'(err_count), 32'b1);
    chk("mid_valid", 32'(out_valid), 32'b1);
    chk("mid_mode", 32'(out_mode), 32'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'b0);
    chk("mid_rst_data", 32'(out_data), 32'b0);
    chk("mid_rst_mode", 32'(out_mode), 32'b0);
    chk("mid_rst_err", 32'(step_err), 32'b0);
    chk("mid_rst_count", 32'(err_count), 32'b0);
    in_valid = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    tick;
    tick;
    chk("mid_post_valid", 32'(out_valid), 32'b0);

    // First Gray word after reset never errors, even far from the old history.
    in_valid = 1'b1;
    in_mode  = 1'b0;
    in_data  = 4'b1111;
    tick;
    in_valid = 1'b0;
    tick;
    chk("first_valid", 32'(out_valid), 32'b1);
    chk("first_data", 32'(out_data), 32'b1010);
    chk("first_err", 32'(step_err), 32'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_bin_pipe.md
Name: gray_bin_pipe

Overview:
Parametrised, pipelined Gray/binary code converter with a valid/ready stream interface on both sides. Each transfer carries its own direction: Gray->binary or binary->Gray.
In Gray->binary mode it also checks that consecutive Gray inputs differ by at most one bit, and counts any violations. It sits on CDC pointer paths and encoder/decoder datapaths, replacing the fixed 4-bit combinational converter.

Parameters:
WIDTH, 4, data width in bits (2..32).
STAGES, 2, register stages from input to output (1..WIDTH); sets the fixed latency.
ERRW, 8, width of the saturating step-error counter.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input word present
in_ready  output  1  block accepts a word this cycle
in_mode  input  1  0 = Gray->binary, 1 = binary->Gray
in_data  input  WIDTH  word to convert
out_valid  output  1  result present
out_ready  input  1  downstream accepts the result
out_data  output  WIDTH  converted word
out_mode  output  1  in_mode of this result, carried alongside it
step_err  output  1  this Gray->binary result violated the one-bit-step rule
err_count  output  ERRW  saturating count of step errors
clr_err  input  1  synchronous clear of err_count

Behaviour:
- Reset (asynchronous, rst_n low):
  - All stage valids = 0, out_valid = 0, out_data = 0, out_mode = 0, step_err = 0, err_count = 0.
  - Gray history register cleared; history-valid flag = 0.
- Pipeline control:
  - Global advance: adv = out_ready | ~out_valid.
  - in_ready = adv, as a combinational function of out_ready and out_valid only.
  - Transfer occurs when in_valid & in_ready.
  - When adv = 1, every stage shifts one position; the stage-0 valid takes in_valid & in_ready.
  - When adv = 0, all stages hold and the output is stable while out_valid = 1.
- Latency: exactly STAGES cycles from accepted input to out_valid when out_ready stays high. Throughput: one word per cycle.
- Gray->binary conversion:
  - bin[WIDTH-1] = g[WIDTH-1]; bin[i] = bin[i+1] ^ g[i].
  - The XOR prefix chain is split across the STAGES registers, MSB-first, with at most ceil(WIDTH/STAGES) bits resolved per stage.
  - Each stage carries its partially resolved bits plus the unresolved Gray bits.
- Binary->Gray conversion: g = b ^ (b >> 1), computed in stage 0 and delayed so that latency is also STAGES. Results never reorder.
- Step check (mode 0 transfers only):
  - On an accepted input, compute the Hamming distance d between in_data and the history register, then load in_data into the history and set history-valid.
  - Error = history-valid & (d > 1). d = 0 (repeated sample) is legal.
  - The error flag travels with the word; step_err is asserted together with that word's out_valid.
  - The first mode-0 word after reset never errors.
- Mode 1 transfers:
  - Do not read or update the history.
  - step_err = 0.
- err_count:
  - Increments when a result with step_err = 1 is transferred out (out_valid & out_ready).
  - Saturates at 2^ERRW-1 and does not wrap.
  - clr_err has priority over a simultaneous increment; the counter is 0 on the next cycle.
- Simultaneous input accept and output transfer in one cycle is legal; both happen.
- Reset mid-stream: in-flight words are discarded; no spurious out_valid after release.
- in_data and in_mode are sampled only on a transfer.

Test Plan:
- WIDTH=4, STAGES=2, out_ready=1. Send mode 0, in_data=0110 -> out_data=0100, out_valid high exactly 2 cycles after acceptance, step_err=0.
- Back-to-back sweep: mode 0, Gray sequence for 0..15 (0000,0001,0011,...,1000), one per cycle -> out_data = 0..15 on consecutive cycles, step_err never set, err_count=0.
- Mode 1, in_data=1011 -> out_data=1110, out_mode=1. Interleave with mode 0 0011 -> 0010; order is preserved and history is unaffected by the mode-1 word.
- Step errors:
  - Mode 0 sequence 0000, 0011 -> second result has step_err=1 and err_count becomes 1 after transfer.
  - Then repeat 0011 -> step_err=0.
- Backpressure:
  - Hold out_ready=0 for 5 cycles with the pipeline full -> in_ready=0, out_data stable.
  - Release -> all words emerge in order with none lost or duplicated.
- Saturation and clear:
  - ERRW=2, force 5 step errors -> err_count=3.
  - clr_err coinciding with an error transfer -> err_count=0.
  - Assert rst_n low mid-stream -> all outputs 0 immediately, no out_valid after release.
